ro_pair_compare: RTL
====================

Name: ro_pair_compare

Overview:
- Measurement controller and arbiter downstream of a pair of 12-bit ring-oscillator edge counters.
- Clears the counters, then opens a fixed enable window on both. After the window it samples both counts, compares them and shifts one PUF response bit per pair into a response word.
- Steps through RESP_W oscillator pairs, selected via pair_sel, per start request, then presents the word to the readout logic.

Parameters:
- CNT_W, 12, width of count_a/count_b from the counters.
- WINDOW, 1024, measurement window length in clk cycles (cnt_en high time); must be >= 1.
- SETTLE, 4, cycles between cnt_en falling and compare, letting the counters' last increments land; must be >= 1.
- RESP_W, 8, response bits per run; also the number of pairs addressed.
- SEL_W, 3, width of pair_sel; must satisfy 2**SEL_W >= RESP_W.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a run; ignored while busy.
- count_a, input, CNT_W, count from counter of oscillator A of selected pair.
- count_b, input, CNT_W, count from counter of oscillator B of selected pair.
- cnt_clr, output, 1, one-cycle pulse clearing both counters before each measurement.
- cnt_en, output, 1, enable to both counters; high for exactly WINDOW cycles per measurement.
- pair_sel, output, SEL_W, index of oscillator pair being measured.
- busy, output, 1, high from the cycle after accepted start until resp_valid.
- resp, output, RESP_W, response word; bit i = result of pair i.
- resp_valid, output, 1, one-cycle pulse when resp is complete.
- tie_flag, output, 1, sticky per run; set if any pair compared equal.
- ovf_flag, output, 1, sticky per run; set if any count read all-ones (possible wrap).

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - All outputs 0: cnt_clr, cnt_en, pair_sel, busy, resp, resp_valid, tie_flag, ovf_flag.
  - Window and settle counters are 0.
- IDLE: start=1 -> CLEAR. On that edge: pair_sel<=0, tie_flag<=0, ovf_flag<=0, resp<=0, busy<=1.
- CLEAR: cnt_clr=1 for one cycle -> MEASURE.
- MEASURE: cnt_en=1 for exactly WINDOW consecutive cycles, counted by an internal counter -> SETTLE.
- SETTLE: cnt_en=0 for SETTLE cycles -> COMPARE.
- COMPARE (one cycle), with count_a/count_b sampled this cycle:
  - bit = (count_a > count_b), unsigned compare.
  - Equal counts -> bit=0 and tie_flag<=1.
  - Either count == 2**CNT_W-1 -> ovf_flag<=1; bit is still computed normally.
  - resp[pair_sel] <= bit.
  - If pair_sel == RESP_W-1 -> DONE. Otherwise pair_sel increments and -> CLEAR.
- DONE (one cycle): resp_valid=1, busy<=0 -> IDLE.
  - resp, tie_flag, ovf_flag hold until the next accepted start.
  - pair_sel holds its last value until the next start.
- start while busy: ignored; no queuing.
- start in the DONE cycle: ignored. start is accepted only in IDLE, i.e. the cycle after resp_valid at the earliest.
- Run latency from start edge to resp_valid: RESP_W*(1+WINDOW+SETTLE+1)+1 cycles.
- cnt_clr and cnt_en are never high in the same cycle.
- cnt_en is low in every state except MEASURE.
- Reset mid-run: immediate abort to the reset state; no resp_valid; partial resp discarded (cleared to 0).

Test Plan:
- Reset release, no start for 50 cycles -> all outputs stay 0; cnt_en never asserts.
- WINDOW=16, SETTLE=2, RESP_W=2; start; model drives count_a=100/count_b=90 for pair 0, then 50/60 for pair 1 -> resp=2'b01, tie_flag=0, ovf_flag=0. resp_valid pulses exactly 2*(1+16+2+1)+1=41 cycles after start; cnt_en high 16 cycles per pair.
- Equal counts 0x7FF/0x7FF on pair 0 -> resp[0]=0, tie_flag=1, and tie_flag stays 1 through resp_valid.
- count_a=0xFFF on one pair -> ovf_flag=1; resp bit = 1 if count_b<0xFFF.
- start pulsed again mid-MEASURE -> ignored; pair_sel sequence and latency unchanged. A second start one cycle after resp_valid begins a new run with flags and resp cleared.
- reset asserted during SETTLE of pair 1 -> outputs 0 asynchronously (before the next clk edge); no resp_valid; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/ro_pair_compare.sv
// Measurement controller for a bank of ring-oscillator pairs: clears and gates a pair of
// edge counters, compares the two counts, and builds one response bit per pair into a word.
module ro_pair_compare #(
   parameter int unsigned CNT_W  = 12,
   parameter int unsigned WINDOW = 1024,
   parameter int unsigned SETTLE = 4,
   parameter int unsigned RESP_W = 8,
   parameter int unsigned SEL_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  count_a,
   input  logic [CNT_W-1:0]  count_b,
   output logic              cnt_clr,
   output logic              cnt_en,
   output logic [SEL_W-1:0]  pair_sel,
   output logic              busy,
   output logic [RESP_W-1:0] resp,
   output logic              resp_valid,
   output logic              tie_flag,
   output logic              ovf_flag
);

   localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_MEASURE,
      S_SETTLE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIN_W-1:0] win_cnt;
   logic [SET_W-1:0] set_cnt;

   logic cmp_bit_c;
   logic tie_c;
   logic ovf_c;
   logic last_pair_c;

   // Compare terms for the pair currently under measurement.
   always_comb begin
      cmp_bit_c   = (count_a > count_b);
      tie_c       = (count_a == count_b);
      ovf_c       = (&count_a) | (&count_b);
      last_pair_c = (pair_sel == SEL_W'(RESP_W - 1));
   end

   // Sequencer; every output is registered so cnt_clr/cnt_en are glitch-free to the counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         win_cnt    <= '0;
         set_cnt    <= '0;
         cnt_clr    <= 1'b0;
         cnt_en     <= 1'b0;
         pair_sel   <= '0;
         busy       <= 1'b0;
         resp       <= '0;
         resp_valid <= 1'b0;
         tie_flag   <= 1'b0;
         ovf_flag   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_CLEAR;
                  cnt_clr  <= 1'b1;
                  pair_sel <= '0;
                  tie_flag <= 1'b0;
                  ovf_flag <= 1'b0;
                  resp     <= '0;
                  busy     <= 1'b1;
               end
            end
            S_CLEAR: begin
               state   <= S_MEASURE;
               cnt_clr <= 1'b0;
               cnt_en  <= 1'b1;
               win_cnt <= '0;
            end
            S_MEASURE: begin
               if (win_cnt == WIN_W'(WINDOW - 1)) begin
                  state   <= S_SETTLE;
                  cnt_en  <= 1'b0;
                  set_cnt <= '0;
               end else begin
                  win_cnt <= win_cnt + WIN_W'(1);
               end
            end
            S_SETTLE: begin
               if (set_cnt == SET_W'(SETTLE - 1)) begin
                  state <= S_COMPARE;
               end else begin
                  set_cnt <= set_cnt + SET_W'(1);
               end
            end
            S_COMPARE: begin
               for (int unsigned i = 0; i < RESP_W; i++) begin
                  if (pair_sel == SEL_W'(i)) resp[i] <= cmp_bit_c;
               end
               if (tie_c) tie_flag <= 1'b1;
               if (ovf_c) ovf_flag <= 1'b1;
               if (last_pair_c) begin
                  state      <= S_DONE;
                  resp_valid <= 1'b1;
               end else begin
                  state    <= S_CLEAR;
                  cnt_clr  <= 1'b1;
                  pair_sel <= pair_sel + SEL_W'(1);
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
